// File: rtl/el2_exu_gfmul_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module   : el2_exu_gfmul_ctl_if
//  Purpose  : Custom-op port bundle between EXU decode and the GF(2^M)
//             multiply unit. Carries the op decode packet, the rs1 operand
//             and the unit's status/readback outputs.
//  Ports    : ff_valid      decode -> unit   custom op issued this cycle
//             ff_pkt        decode -> unit   op decode (ffload*/ffmul*)
//             ff_rs1        decode -> unit   operand word / read index
//             ff_flush      decode -> unit   pipeline flush
//             ff_busy       unit -> decode   multiply in progress
//             ff_result     unit -> decode   registered read data
//             ff_result_vld unit -> decode   read data valid pulse
//             ff_error      unit -> decode   sticky illegal-use flag
//  Revision : 1.0  initial release
// ============================================================================
interface el2_exu_gfmul_ctl_if;

   // One-hot op field; valid qualifies the whole packet.
   typedef struct packed {
      logic valid;
      logic ffloadas;
      logic ffloada;
      logic ffloadae;
      logic ffloadbs;
      logic ffloadb;
      logic ffloadbe;
      logic ffmul1;
      logic ffmul2;
      logic ffmul3;
      logic ffmul4;
   } el2_custom_pkt_t;

   logic            ff_valid;
   el2_custom_pkt_t ff_pkt;
   logic [31:0]     ff_rs1;
   logic            ff_flush;
   logic            ff_busy;
   logic [31:0]     ff_result;
   logic            ff_result_vld;
   logic            ff_error;

   // Decode side
   modport master (
      output ff_valid, ff_pkt, ff_rs1, ff_flush,
      input  ff_busy, ff_result, ff_result_vld, ff_error
   );

   // Multiply unit side
   modport slave (
      input  ff_valid, ff_pkt, ff_rs1, ff_flush,
      output ff_busy, ff_result, ff_result_vld, ff_error
   );

endinterface
`default_nettype wire

// File: rtl/el2_exu_gfmul_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : el2_exu_gfmul_ctl
//  Purpose  : Iterative GF(2^M) multiplier, M = 32*NWORDS, reduction
//             polynomial x^M + POLY. Operands A and B are loaded one 32-bit
//             word per custom op; ffmul1 starts a multiply that consumes
//             BITS_PER_CYC bits of B per cycle, MSB first; result words are
//             read back through a registered port.
//  Ports    : clk    core clock
//             rst_l  synchronous reset, active low
//             ff     el2_exu_gfmul_ctl_if.slave (op in, status/readback out)
//  Revision : 1.0  initial release
// ============================================================================
module el2_exu_gfmul_ctl #(
   parameter int                 NWORDS       = 4,
   parameter logic [32*NWORDS-1:0] POLY       = 'h87,
   parameter int                 BITS_PER_CYC = 1
) (
   input  logic                 clk,
   input  logic                 rst_l,
   el2_exu_gfmul_ctl_if.slave   ff
);

   localparam int c_M     = 32 * NWORDS;
   localparam int c_STEPS = c_M / BITS_PER_CYC;
   localparam int c_CNTW  = $clog2(c_STEPS);
   localparam int c_SHW   = $clog2(c_M);
   // Pointer must be able to hold NWORDS itself (the "operand full" value).
   localparam int c_PTRW  = $clog2(NWORDS + 1);
   localparam int c_IDXW  = $clog2(NWORDS);
   localparam logic [2:0]        c_IDX_MASK = 3'((1 << c_IDXW) - 1);
   localparam logic [c_CNTW-1:0] c_LAST     = c_CNTW'(c_STEPS - 1);
   localparam logic [c_PTRW-1:0] c_PTR_FULL = c_PTRW'(NWORDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [c_M-1:0]      r_a;
   logic [c_M-1:0]      r_b;
   logic [c_M-1:0]      r_z;
   logic [c_PTRW-1:0]   r_ptr_a;
   logic [c_PTRW-1:0]   r_ptr_b;
   logic                r_a_full;
   logic                r_b_full;
   logic [c_CNTW-1:0]   r_cnt;
   logic                r_error;
   logic [31:0]         r_result;
   logic                r_result_vld;

   logic                w_op;
   logic                w_cmd;
   logic                w_busy;
   logic                w_done;
   logic                w_start;
   logic                w_step;
   logic                w_abort;
   logic                w_mul_err;
   logic                w_start_err;
   logic                w_clr4;

   logic                w_lda_s, w_lda, w_lda_e, w_a_ovf, w_a_wr;
   logic                w_ldb_s, w_ldb, w_ldb_e, w_b_ovf, w_b_wr;
   logic [c_PTRW-1:0]   w_a_widx;
   logic [c_PTRW-1:0]   w_b_widx;

   logic                w_rd2;
   logic                w_rd3;
   logic [2:0]          w_idx;
   logic                w_idx_bad;
   logic [31:0]         w_zword;

   logic [c_SHW-1:0]        w_shamt;
   logic [BITS_PER_CYC-1:0] w_bslice;
   logic [c_M-1:0]          w_z_nxt;
   logic                    w_err_set;

   // ------------------------------------------------------------------------
   // Op qualification. A flush suppresses every op. While multiplying, ops
   // are not executed (they only raise ff_error), so w_cmd excludes MUL.
   // ------------------------------------------------------------------------
   assign w_busy = (r_state == S_MUL);
   assign w_done = (r_state == S_DONE);
   assign w_op   = ff.ff_valid & ff.ff_pkt.valid & ~ff.ff_flush;
   assign w_cmd  = w_op & ~w_busy;

   assign w_clr4      = w_cmd & ff.ff_pkt.ffmul4;
   assign w_start_err = w_cmd & ff.ff_pkt.ffmul1 & ~(r_a_full & r_b_full);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_l) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and datapath controls
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_step      = 1'b0;
      w_abort     = 1'b0;
      w_mul_err   = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_cmd && ff.ff_pkt.ffmul1 && r_a_full && r_b_full) begin
               w_start     = 1'b1;
               w_state_nxt = S_MUL;
            end else if (w_clr4) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_MUL: begin
            if (ff.ff_flush) begin
               // Flush wins over any op presented in the same cycle.
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_step    = 1'b1;
               w_mul_err = w_op;
               if (r_cnt == c_LAST) begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Operand load decode. The *s ops restart at word 0; writes past the last
   // word are dropped and flagged, leaving the pointer saturated.
   // ------------------------------------------------------------------------
   assign w_lda_s  = w_cmd & ff.ff_pkt.ffloadas;
   assign w_lda    = w_cmd & (ff.ff_pkt.ffloada | ff.ff_pkt.ffloadae);
   assign w_lda_e  = w_cmd & ff.ff_pkt.ffloadae;
   assign w_a_ovf  = w_lda & (r_ptr_a == c_PTR_FULL);
   assign w_a_wr   = w_lda_s | (w_lda & ~w_a_ovf);
   assign w_a_widx = w_lda_s ? '0 : r_ptr_a;

   assign w_ldb_s  = w_cmd & ff.ff_pkt.ffloadbs;
   assign w_ldb    = w_cmd & (ff.ff_pkt.ffloadb | ff.ff_pkt.ffloadbe);
   assign w_ldb_e  = w_cmd & ff.ff_pkt.ffloadbe;
   assign w_b_ovf  = w_ldb & (r_ptr_b == c_PTR_FULL);
   assign w_b_wr   = w_ldb_s | (w_ldb & ~w_b_ovf);
   assign w_b_widx = w_ldb_s ? '0 : r_ptr_b;

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         r_a      <= '0;
         r_ptr_a  <= '0;
         r_a_full <= 1'b0;
      end else begin
         for (int w = 0; w < NWORDS; w++) begin
            if (w_a_wr && (w_a_widx == c_PTRW'(w))) begin
               r_a[32*w +: 32] <= ff.ff_rs1;
            end
         end
         if (w_lda_s) begin
            r_ptr_a  <= c_PTRW'(1);
            r_a_full <= 1'b0;
         end else if (w_lda && !w_a_ovf) begin
            r_ptr_a <= r_ptr_a + c_PTRW'(1);
            if (w_lda_e) begin
               r_a_full <= 1'b1;
            end
         end else if (w_clr4) begin
            r_a_full <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         r_b      <= '0;
         r_ptr_b  <= '0;
         r_b_full <= 1'b0;
      end else begin
         for (int w = 0; w < NWORDS; w++) begin
            if (w_b_wr && (w_b_widx == c_PTRW'(w))) begin
               r_b[32*w +: 32] <= ff.ff_rs1;
            end
         end
         if (w_ldb_s) begin
            r_ptr_b  <= c_PTRW'(1);
            r_b_full <= 1'b0;
         end else if (w_ldb && !w_b_ovf) begin
            r_ptr_b <= r_ptr_b + c_PTRW'(1);
            if (w_ldb_e) begin
               r_b_full <= 1'b1;
            end
         end else if (w_clr4) begin
            r_b_full <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Multiply step. Horner evaluation over B, MSB first: step r_cnt handles
   // B bits [M-1-r_cnt*BPC -: BPC]. B is never shifted in place so that a
   // flushed multiply can be reissued without reloading.
   // ------------------------------------------------------------------------
   assign w_shamt  = c_SHW'(c_M - BITS_PER_CYC * (int'(r_cnt) + 1));
   assign w_bslice = BITS_PER_CYC'(r_b >> w_shamt);

   always_comb begin
      w_z_nxt = r_z;
      for (int j = BITS_PER_CYC - 1; j >= 0; j--) begin
         // Multiply by x, folding the x^M term back in via POLY.
         w_z_nxt = {w_z_nxt[c_M-2:0], 1'b0} ^ (w_z_nxt[c_M-1] ? POLY : '0);
         if (w_bslice[j]) begin
            w_z_nxt = w_z_nxt ^ r_a;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         r_z   <= '0;
         r_cnt <= '0;
      end else if (w_start || w_abort) begin
         r_z   <= '0;
         r_cnt <= '0;
      end else if (w_step) begin
         r_z   <= w_z_nxt;
         r_cnt <= r_cnt + c_CNTW'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Readback. Only the low ceil(log2 NWORDS) index bits are used; with a
   // non-power-of-two NWORDS the remaining codes read as 0 and flag an error.
   // ------------------------------------------------------------------------
   assign w_rd2     = w_cmd & ff.ff_pkt.ffmul2;
   assign w_rd3     = w_cmd & ff.ff_pkt.ffmul3;
   assign w_idx     = ff.ff_rs1[2:0] & c_IDX_MASK;
   assign w_idx_bad = (int'(w_idx) >= NWORDS);

   always_comb begin
      w_zword = '0;
      for (int w = 0; w < NWORDS; w++) begin
         if (w_idx == 3'(w)) begin
            w_zword = r_z[32*w +: 32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         r_result     <= '0;
         r_result_vld <= 1'b0;
      end else begin
         r_result_vld <= w_rd2 | w_rd3;
         if (w_rd2) begin
            r_result <= w_idx_bad ? 32'd0 : w_zword;
         end else if (w_rd3) begin
            r_result <= {29'd0, r_error, w_done, w_busy};
         end
      end
   end

   // ------------------------------------------------------------------------
   // Sticky error flag
   // ------------------------------------------------------------------------
   assign w_err_set = w_mul_err | w_start_err | w_a_ovf | w_b_ovf
                    | (w_rd2 & w_idx_bad);

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         r_error <= 1'b0;
      end else if (w_clr4) begin
         r_error <= 1'b0;
      end else if (w_err_set) begin
         r_error <= 1'b1;
      end
   end

   assign ff.ff_busy       = w_busy;
   assign ff.ff_result     = r_result;
   assign ff.ff_result_vld = r_result_vld;
   assign ff.ff_error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_el2_exu_gfmul_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_el2_exu_gfmul_ctl
//  Purpose  : Bench for el2_exu_gfmul_ctl. Two units (1 and 4 bits per
//             cycle) receive identical op streams; each is tracked by an
//             abstract model that computes products by full carry-less
//             multiplication followed by polynomial reduction.
//  Revision : 1.0  initial release
// ============================================================================
module tb_el2_exu_gfmul_ctl;

   localparam int         M       = 128;
   localparam logic [M-1:0] POLY_LO = 128'h87;
   localparam int         c_STEPS [2] = '{128, 32};

   // op codes used by the bench
   localparam int OP_LAS = 0, OP_LA = 1, OP_LAE = 2;
   localparam int OP_LBS = 3;
   localparam int OP_M1 = 6, OP_M2 = 7, OP_M3 = 8, OP_M4 = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        s_rst_l;
   logic        s_valid;
   int          s_op;
   logic [31:0] s_rs1;
   logic        s_flush;
   logic [10:0] s_pkt;

   // {valid, ffloadas, ffloada, ffloadae, ffloadbs, ffloadb, ffloadbe,
   //  ffmul1, ffmul2, ffmul3, ffmul4}
   always_comb begin
      s_pkt = 11'd0;
      if (s_valid && s_op >= 0) s_pkt = {1'b1, 10'(10'd1 << (9 - s_op))};
   end

   el2_exu_gfmul_ctl_if u_if1 ();
   el2_exu_gfmul_ctl_if u_if4 ();

   assign u_if1.ff_valid = s_valid;
   assign u_if1.ff_pkt   = s_pkt;
   assign u_if1.ff_rs1   = s_rs1;
   assign u_if1.ff_flush = s_flush;
   assign u_if4.ff_valid = s_valid;
   assign u_if4.ff_pkt   = s_pkt;
   assign u_if4.ff_rs1   = s_rs1;
   assign u_if4.ff_flush = s_flush;

   el2_exu_gfmul_ctl #(.NWORDS(4), .POLY(128'h87), .BITS_PER_CYC(1)) u_dut1 (
      .clk(clk), .rst_l(s_rst_l), .ff(u_if1.slave));
   el2_exu_gfmul_ctl #(.NWORDS(4), .POLY(128'h87), .BITS_PER_CYC(4)) u_dut4 (
      .clk(clk), .rst_l(s_rst_l), .ff(u_if4.slave));

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // ---------------- behavioural model, one slot per unit ----------------
   logic [M-1:0] m_a [2];
   logic [M-1:0] m_b [2];
   logic [M-1:0] m_z [2];
   int           m_pa [2];
   int           m_pb [2];
   logic         m_af [2];
   logic         m_bf [2];
   logic         m_err [2];
   logic         m_done [2];
   int           m_rem [2];   // cycles of multiply remaining; >0 means busy
   logic         m_vld [2];
   logic [31:0]  m_res [2];

   function automatic logic [M-1:0] gfmul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [2*M-1:0] p;
      logic [2*M-1:0] fp;
      p  = '0;
      fp = '0;
      fp[M] = 1'b1;
      fp[M-1:0] = POLY_LO;
      for (int i = 0; i < M; i++)
         if (b[i]) p = p ^ ({{M{1'b0}}, a} << i);
      for (int i = 2*M-1; i >= M; i--)
         if (p[i]) p = p ^ (fp << (i - M));
      return p[M-1:0];
   endfunction

   task automatic model_reset(input int k);
      m_a[k] = '0; m_b[k] = '0; m_z[k] = '0;
      m_pa[k] = 0; m_pb[k] = 0; m_af[k] = 1'b0; m_bf[k] = 1'b0;
      m_err[k] = 1'b0; m_done[k] = 1'b0; m_rem[k] = 0;
      m_vld[k] = 1'b0; m_res[k] = '0;
   endtask

   task automatic model_update();
      bit cmd;
      int idx;
      cmd = s_valid && (s_op >= 0) && !s_flush;
      for (int k = 0; k < 2; k++) begin
         if (!s_rst_l) begin
            model_reset(k);
         end else begin
            m_vld[k] = 1'b0;
            if (m_rem[k] > 0) begin
               if (s_flush) begin
                  m_rem[k] = 0;
                  m_z[k]   = '0;
               end else begin
                  if (cmd) m_err[k] = 1'b1;
                  m_rem[k]--;
                  if (m_rem[k] == 0) begin
                     m_done[k] = 1'b1;
                     m_z[k]    = gfmul(m_a[k], m_b[k]);
                  end
               end
            end else if (cmd) begin
               case (s_op)
                  0: begin m_a[k][31:0] = s_rs1; m_pa[k] = 1; m_af[k] = 1'b0; end
                  1, 2: begin
                     if (m_pa[k] == 4) m_err[k] = 1'b1;
                     else begin
                        m_a[k][32*m_pa[k] +: 32] = s_rs1;
                        m_pa[k]++;
                        if (s_op == 2) m_af[k] = 1'b1;
                     end
                  end
                  3: begin m_b[k][31:0] = s_rs1; m_pb[k] = 1; m_bf[k] = 1'b0; end
                  4, 5: begin
                     if (m_pb[k] == 4) m_err[k] = 1'b1;
                     else begin
                        m_b[k][32*m_pb[k] +: 32] = s_rs1;
                        m_pb[k]++;
                        if (s_op == 5) m_bf[k] = 1'b1;
                     end
                  end
                  6: begin
                     if (m_af[k] && m_bf[k]) begin
                        m_rem[k] = c_STEPS[k]; m_done[k] = 1'b0; m_z[k] = '0;
                     end else m_err[k] = 1'b1;
                  end
                  7: begin
                     idx = int'(s_rs1[1:0]);
                     m_vld[k] = 1'b1;
                     m_res[k] = m_z[k][32*idx +: 32];
                  end
                  8: begin
                     m_vld[k] = 1'b1;
                     m_res[k] = {29'd0, m_err[k], m_done[k], 1'b0};
                  end
                  default: begin
                     m_err[k] = 1'b0; m_done[k] = 1'b0;
                     m_af[k] = 1'b0; m_bf[k] = 1'b0;
                  end
               endcase
            end
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // {busy, error, result_vld, result}
   function automatic logic [34:0] dut_out(input int k);
      if (k == 0)
         return {u_if1.ff_busy, u_if1.ff_error, u_if1.ff_result_vld, u_if1.ff_result};
      return {u_if4.ff_busy, u_if4.ff_error, u_if4.ff_result_vld, u_if4.ff_result};
   endfunction

   always @(negedge clk) begin
      logic [34:0] o;
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            o = dut_out(k);
            check($sformatf("busy[u%0d]", k), {31'd0, o[34]}, {31'd0, m_rem[k] > 0});
            check($sformatf("error[u%0d]", k), {31'd0, o[33]}, {31'd0, m_err[k]});
            check($sformatf("vld[u%0d]", k), {31'd0, o[32]}, {31'd0, m_vld[k]});
            if (m_vld[k]) check($sformatf("result[u%0d]", k), o[31:0], m_res[k]);
         end
      end
   end

   task automatic lit_res(input string name, input int k, input logic [31:0] exp);
      logic [34:0] o;
      o = dut_out(k);
      check(name, o[31:0], exp);
   endtask

   task automatic lit_busy(input string name, input int k, input logic exp);
      logic [34:0] o;
      o = dut_out(k);
      check(name, {31'd0, o[34]}, {31'd0, exp});
   endtask

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic op(input int o, input logic [31:0] d);
      s_valid = 1'b1; s_op = o; s_rs1 = d;
      tick();
      s_valid = 1'b0; s_op = -1;
   endtask

   // base OP_LAS loads A, OP_LBS loads B (start, mid, mid, end)
   task automatic load4(input int base, input logic [M-1:0] v);
      op(base,     v[31:0]);
      op(base + 1, v[63:32]);
      op(base + 1, v[95:64]);
      op(base + 2, v[127:96]);
   endtask

   task automatic wait_idle(output int c1, output int c4);
      bit ok;
      c1 = 0; c4 = 0; ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!u_if1.ff_busy && !u_if4.ff_busy) begin ok = 1'b1; break; end
         if (u_if1.ff_busy) c1++;
         if (u_if4.ff_busy) c4++;
         tick();
      end
      if (!ok) begin
         n_tests++; n_fail++;
         $display("FAIL busy-timeout: still busy after 300 cycles, expected idle");
      end
   endtask

   initial begin
      int c1, c4;
      logic [M-1:0] ra, rb, prod;
      s_rst_l = 1'b0; s_valid = 1'b0; s_op = -1; s_rs1 = '0; s_flush = 1'b0;
      for (int k = 0; k < 2; k++) model_reset(k);
      @(negedge clk);
      tick(); tick();
      chk_en  = 1'b1;
      s_rst_l = 1'b1;
      for (int k = 0; k < 2; k++) begin
         lit_res("reset result", k, 32'd0);
         lit_busy("reset busy", k, 1'b0);
      end

      // 1 * 1 = 1
      load4(OP_LAS, 128'h1);
      load4(OP_LBS, 128'h1);
      op(OP_M1, 0);
      lit_busy("busy after ffmul1 u0", 0, 1'b1);
      lit_busy("busy after ffmul1 u1", 1, 1'b1);
      wait_idle(c1, c4);
      check("latency B=1", c1, 32'd128);
      check("latency B=4", c4, 32'd32);
      for (int k = 0; k < 2; k++) begin
         op(OP_M2, 0); lit_res("1*1 w0", k, 32'h1);
         op(OP_M2, 1); lit_res("1*1 w1", k, 32'h0);
         op(OP_M2, 3); lit_res("1*1 w3", k, 32'h0);
      end

      // x^127 * x = x^128 = x^7+x^2+x+1
      load4(OP_LAS, {32'h8000_0000, 96'd0});
      load4(OP_LBS, 128'h2);
      op(OP_M1, 0);
      wait_idle(c1, c4);
      for (int k = 0; k < 2; k++) begin
         op(OP_M2, 0); lit_res("x127*x w0", k, 32'h0000_0087);
         op(OP_M2, 1); lit_res("x127*x w1", k, 32'h0);
         op(OP_M2, 2); lit_res("x127*x w2", k, 32'h0);
      end

      // start with only A full
      op(OP_M4, 0);
      load4(OP_LAS, 128'h5);
      op(OP_M1, 0);
      lit_busy("no start u0", 0, 1'b0);
      lit_busy("no start u1", 1, 1'b0);
      op(OP_M3, 0);
      lit_res("status after bad start u0", 0, 32'h4);
      lit_res("status after bad start u1", 1, 32'h4);
      op(OP_M4, 0);
      op(OP_M3, 0);
      lit_res("status after ffmul4", 0, 32'h0);

      // fifth load dropped
      op(OP_LAS, 32'h11); op(OP_LA, 32'h22); op(OP_LA, 32'h33);
      op(OP_LAE, 32'h44); op(OP_LA, 32'h55);
      op(OP_M3, 0);
      lit_res("overflow status", 0, 32'h4);
      load4(OP_LBS, 128'h1);
      op(OP_M1, 0);
      wait_idle(c1, c4);
      for (int k = 0; k < 2; k++) begin
         op(OP_M2, 3); lit_res("overflow w3", k, 32'h44);
         op(OP_M2, 0); lit_res("overflow w0", k, 32'h11);
         op(OP_M3, 0); lit_res("overflow done status", k, 32'h6);
      end

      // flush at cycle 50, then reissue
      op(OP_M4, 0);
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      prod = gfmul(ra, rb);
      load4(OP_LAS, ra);
      load4(OP_LBS, rb);
      op(OP_M1, 0);
      repeat (49) tick();
      s_flush = 1'b1;
      tick();
      s_flush = 1'b0;
      lit_busy("busy after flush", 0, 1'b0);
      op(OP_M2, 0);
      lit_res("Z cleared by flush", 0, 32'h0);
      lit_res("B=4 unaffected by flush", 1, prod[31:0]);
      op(OP_M1, 0);
      wait_idle(c1, c4);
      check("reissue latency B=1", c1, 32'd128);
      for (int w = 0; w < 4; w++) begin
         op(OP_M2, w);
         lit_res($sformatf("reissue w%0d u0", w), 0, prod[32*w +: 32]);
         lit_res($sformatf("reissue w%0d u1", w), 1, prod[32*w +: 32]);
      end

      // reset in the middle of a multiply
      op(OP_M1, 0);
      repeat (10) tick();
      s_rst_l = 1'b0;
      tick();
      s_rst_l = 1'b1;
      lit_busy("busy after reset", 0, 1'b0);
      op(OP_M3, 0);
      lit_res("status after reset", 0, 32'h0);
      op(OP_M1, 0);
      lit_busy("no start after reset", 0, 1'b0);
      op(OP_M2, 0);
      lit_res("Z after reset", 0, 32'h0);

      // randomized traffic, with periodic clean multiplies
      for (int i = 0; i < 4000; i++) begin
         int r;
         if (i % 400 == 0) begin
            s_rst_l = 1'b1; s_flush = 1'b0;
            load4(OP_LAS, {$urandom, $urandom, $urandom, $urandom});
            load4(OP_LBS, {$urandom, $urandom, $urandom, $urandom});
            op(OP_M1, 0);
            wait_idle(c1, c4);
            for (int w = 0; w < 4; w++) op(OP_M2, w);
         end
         r = int'($urandom_range(0, 999));
         s_rst_l = (r != 0);
         s_flush = (r >= 1 && r <= 5);
         if ($urandom_range(0, 1) == 1) begin
            s_valid = 1'b1; s_op = int'($urandom_range(0, 9)); s_rs1 = $urandom;
         end else begin
            s_valid = 1'b0; s_op = -1;
         end
         tick();
      end
      s_rst_l = 1'b1; s_flush = 1'b0; s_valid = 1'b0; s_op = -1;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
